// File: rtl/stripes_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stripes_ctrl_pkg : shared types and helpers for the Stripes sequencer    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package stripes_ctrl_pkg;

  localparam int MAX_PREC = 8;
  localparam int PREC_W   = $clog2(MAX_PREC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } ctrl_state_e;

  // Zero or out-of-range precisions fall back to the full serial width.
  function automatic int clamp_prec(input int prec, input int max_prec);
    return ((prec == 0) || (prec > max_prec)) ? max_prec : prec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_bit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_bit_serializer : active weight register, bit counter, lane mux    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module weight_bit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int PREC_W     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  issue,
  input  logic                                  bypass,
  input  logic                                  reload,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] load_data,
  input  logic [PREC_W-1:0]                     load_prec,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic                                  is_msb,
  output logic                                  last_bit
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] data_q, data_d, src_data;
  logic [PREC_W-1:0]                     prec_q, prec_d, src_prec;
  logic [PREC_W-1:0]                     bidx_q, bidx_d, src_bidx;
  logic [IDX_W-1:0]                      bit_sel;

  // A bypass issues the MSB straight from the loading vector, so the
  // counter that gets stored is already one step past prec-1.
  always_comb begin
    src_data = bypass ? load_data : data_q;
    src_prec = bypass ? load_prec : prec_q;
    src_bidx = bypass ? (load_prec - PREC_W'(1)) : bidx_q;
    bit_sel  = IDX_W'(src_bidx);
    last_bit = issue && (src_bidx == '0);
    is_msb   = issue && (src_bidx == (src_prec - PREC_W'(1)));

    data_d = data_q;
    prec_d = prec_q;
    bidx_d = bidx_q;
    if (reload) begin
      data_d = load_data;
      prec_d = load_prec;
      bidx_d = load_prec - PREC_W'(1);
    end else if (issue) begin
      data_d = src_data;
      prec_d = src_prec;
      bidx_d = (src_bidx != '0) ? (src_bidx - PREC_W'(1)) : src_bidx;
    end
  end

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    assign w_bit[j] = issue & src_data[j][bit_sel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      prec_q <= '0;
      bidx_q <= '0;
    end else begin
      data_q <= data_d;
      prec_q <= prec_d;
      bidx_q <= bidx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stripes_bit_serial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stripes_bit_serial_ctrl : double-buffered bit-serial weight sequencer    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stripes_bit_serial_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int MAX_PREC   = stripes_ctrl_pkg::MAX_PREC,
  parameter int PREC_W     = $clog2(MAX_PREC + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_data,
  input  logic [PREC_W-1:0]                     w_prec,
  input  logic                                  w_last,
  output logic                                  act_adv,
  output logic                                  mac_en,
  output logic                                  is_msb,
  output logic                                  delayed_is_msb,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic                                  res_valid,
  output logic                                  res_last,
  output logic                                  busy
);

  import stripes_ctrl_pkg::*;

  ctrl_state_e                           state_q, state_d;
  logic                                  shadow_full_q, shadow_full_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
  logic [PREC_W-1:0]                     shadow_prec_q, shadow_prec_d;
  logic                                  shadow_last_q, shadow_last_d;
  logic                                  active_last_q, active_last_d;
  logic                                  dmsb_q, dmsb_d;
  logic                                  pipe_v1_q, pipe_v1_d, pipe_l1_q, pipe_l1_d;
  logic                                  pipe_v2_q, pipe_v2_d, pipe_l2_q, pipe_l2_d;
  logic                                  issue, bypass, reload, drain, last_bit, cur_last;
  logic                                  handshake;

  weight_bit_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .VEC_LENGTH(VEC_LENGTH),
    .PREC_W    (PREC_W)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .bypass   (bypass),
    .reload   (reload),
    .load_data(shadow_data_q),
    .load_prec(shadow_prec_q),
    .w_bit    (w_bit),
    .is_msb   (is_msb),
    .last_bit (last_bit)
  );

  always_comb begin
    w_ready   = !shadow_full_q;
    handshake = w_valid && !shadow_full_q;
    bypass    = (state_q == ST_IDLE) && shadow_full_q;
    issue     = bypass || (state_q == ST_STREAM);
    drain     = (state_q == ST_DRAIN);
    reload    = (state_q == ST_STREAM) && last_bit && shadow_full_q;
    cur_last  = bypass ? shadow_last_q : active_last_q;
    mac_en    = issue || drain;
    act_adv   = last_bit;
    busy      = (state_q != ST_IDLE) || shadow_full_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (shadow_full_q) state_d = last_bit ? ST_DRAIN : ST_STREAM;
      ST_STREAM: if (last_bit && !shadow_full_q) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Consume and refill never coincide: a handshake needs the shadow empty.
    shadow_full_d = shadow_full_q;
    shadow_data_d = shadow_data_q;
    shadow_prec_d = shadow_prec_q;
    shadow_last_d = shadow_last_q;
    if (bypass || reload) shadow_full_d = 1'b0;
    if (handshake) begin
      shadow_full_d = 1'b1;
      shadow_data_d = w_data;
      shadow_prec_d = PREC_W'(clamp_prec(int'(w_prec), MAX_PREC));
      shadow_last_d = w_last;
    end

    active_last_d = (bypass || reload) ? shadow_last_q : active_last_q;
    dmsb_d        = mac_en ? is_msb : dmsb_q;

    // Stage 2 clears on idle cycles so res_valid is a single-cycle pulse.
    pipe_v1_d = mac_en ? last_bit : pipe_v1_q;
    pipe_l1_d = mac_en ? cur_last : pipe_l1_q;
    pipe_v2_d = mac_en && pipe_v1_q;
    pipe_l2_d = mac_en ? pipe_l1_q : pipe_l2_q;

    delayed_is_msb = dmsb_q;
    res_valid      = pipe_v2_q;
    res_last       = pipe_v2_q && pipe_l2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shadow_full_q <= 1'b0;
      shadow_data_q <= '0;
      shadow_prec_q <= '0;
      shadow_last_q <= 1'b0;
      active_last_q <= 1'b0;
      dmsb_q        <= 1'b0;
      pipe_v1_q     <= 1'b0;
      pipe_l1_q     <= 1'b0;
      pipe_v2_q     <= 1'b0;
      pipe_l2_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_full_q <= shadow_full_d;
      shadow_data_q <= shadow_data_d;
      shadow_prec_q <= shadow_prec_d;
      shadow_last_q <= shadow_last_d;
      active_last_q <= active_last_d;
      dmsb_q        <= dmsb_d;
      pipe_v1_q     <= pipe_v1_d;
      pipe_l1_q     <= pipe_l1_d;
      pipe_v2_q     <= pipe_v2_d;
      pipe_l2_q     <= pipe_l2_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stripes_bit_serial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stripes_bit_serial_ctrl : schedule-based reference bench              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_stripes_bit_serial_ctrl;

  localparam int DW   = 8;
  localparam int VL   = 16;
  localparam int PW   = 4;
  localparam int NCYC = 2048;

  typedef logic [VL-1:0][DW-1:0] vec_data_t;
  typedef struct {
    vec_data_t  d;
    logic [3:0] prec;
    bit         lst;
    int         gap;
  } vec_t;

  logic          clk = 1'b1;
  logic          reset;
  logic          w_valid, w_ready, w_last;
  vec_data_t     w_data;
  logic [PW-1:0] w_prec;
  logic          act_adv, mac_en, is_msb, delayed_is_msb, res_valid, res_last, busy;
  logic [VL-1:0] w_bit;

  always #5 clk = ~clk;

  stripes_bit_serial_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .w_prec        (w_prec),
    .w_last        (w_last),
    .act_adv       (act_adv),
    .mac_en        (mac_en),
    .is_msb        (is_msb),
    .delayed_is_msb(delayed_is_msb),
    .w_bit         (w_bit),
    .res_valid     (res_valid),
    .res_last      (res_last),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Expected per-cycle outputs, filled from each vector's start time.
  bit            e_en [NCYC];
  bit            e_msb[NCYC];
  bit            e_adv[NCYC];
  bit            e_rv [NCYC];
  bit            e_rl [NCYC];
  logic [VL-1:0] e_bits[NCYC];
  int            last_l     = -10;
  int            busy_until = -1;
  int            last_start = 0;
  bit            dmsb_m     = 1'b0;
  vec_t          q[$];
  int            gap_cnt    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_prec(input logic [3:0] p);
    return ((p == 0) || (p > 8)) ? 8 : int'(p);
  endfunction

  task automatic schedule(input int h, input vec_data_t d, input int p, input bit lst);
    int s;
    if (h < last_l) begin
      s = last_l + 1;
      busy_until = last_l;
    end else if (h == last_l) begin
      s = h + 2;
      busy_until = s;
    end else begin
      s = h + 1;
      busy_until = s;
    end
    for (int k = 0; k < p; k++) begin
      if (s + k < NCYC) begin
        e_en[s+k]  = 1'b1;
        e_msb[s+k] = (k == 0);
        e_adv[s+k] = (k == p - 1);
        for (int j = 0; j < VL; j++) e_bits[s+k][j] = d[j][p-1-k];
      end
    end
    if (s + p + 1 < NCYC) begin
      e_en[s+p]   = 1'b1;
      e_msb[s+p]  = 1'b0;
      e_adv[s+p]  = 1'b0;
      e_bits[s+p] = '0;
      e_rv[s+p+1] = 1'b1;
      e_rl[s+p+1] = lst;
    end
    last_l     = s + p - 1;
    last_start = s;
  endtask

  task automatic model_reset();
    for (int c = cyc + 1; c < NCYC; c++) begin
      e_en[c] = 0; e_msb[c] = 0; e_adv[c] = 0; e_rv[c] = 0; e_rl[c] = 0; e_bits[c] = '0;
    end
    last_l     = -10;
    busy_until = -1;
    dmsb_m     = 1'b0;
  endtask

  task automatic enqueue(input vec_data_t d, input logic [3:0] p, input bit lst, input int gap);
    vec_t v;
    v.d = d; v.prec = p; v.lst = lst; v.gap = gap;
    if (q.size() == 0) gap_cnt = gap;
    q.push_back(v);
  endtask

  task automatic tick(input bit do_reset);
    bit rdy, hs;
    if (cyc >= NCYC - 16) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, NCYC - 16);
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1);
    end
    reset = do_reset;
    rdy   = (cyc > busy_until);
    if (!do_reset && gap_cnt == 0 && q.size() > 0) begin
      w_valid = 1'b1; w_data = q[0].d; w_prec = q[0].prec; w_last = q[0].lst;
    end else begin
      w_valid = 1'b0; w_prec = PW'($urandom); w_last = 1'($urandom);
      for (int j = 0; j < VL; j++) w_data[j] = DW'($urandom);
    end
    hs = w_valid && rdy;
    if (hs) begin
      schedule(cyc, q[0].d, model_prec(q[0].prec), q[0].lst);
      void'(q.pop_front());
      if (q.size() > 0) gap_cnt = q[0].gap;
    end else if (!do_reset && gap_cnt > 0) begin
      gap_cnt--;
    end
    @(negedge clk);
    if (!do_reset) begin
      check_val("mac_en",    mac_en,         e_en[cyc]);
      check_val("is_msb",    is_msb,         e_msb[cyc]);
      check_val("w_bit",     w_bit,          e_bits[cyc]);
      check_val("act_adv",   act_adv,        e_adv[cyc]);
      check_val("res_valid", res_valid,      e_rv[cyc]);
      check_val("res_last",  res_last,       e_rl[cyc]);
      check_val("w_ready",   w_ready,        rdy);
      check_val("dly_msb",   delayed_is_msb, dmsb_m);
      check_val("busy",      busy,           e_en[cyc] || !rdy);
      if (e_en[cyc]) dmsb_m = e_msb[cyc];
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_queue();
    int budget = 1000;
    while (q.size() > 0 && budget > 0) begin
      tick(1'b0);
      budget--;
    end
    if (q.size() > 0) begin
      check_val("queue_timeout", q.size(), 0);
      q.delete();
    end
    repeat (12) tick(1'b0);
  endtask

  function automatic vec_data_t fill(input logic [DW-1:0] v);
    vec_data_t d;
    for (int j = 0; j < VL; j++) d[j] = v;
    return d;
  endfunction

  function automatic vec_data_t rand_vec();
    vec_data_t d;
    for (int j = 0; j < VL; j++) d[j] = DW'($urandom);
    return d;
  endfunction

  initial begin
    int guard;
    reset = 1'b1; w_valid = 1'b0; w_data = '0; w_prec = '0; w_last = 1'b0;
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);

    // Single isolated prec-8 vector of 8'h81.
    enqueue(fill(8'h81), 4'd8, 1'b1, 0);
    run_queue();

    // Back-to-back mixed precision.
    enqueue(fill(8'hAF), 4'd4, 1'b0, 0);
    enqueue(fill(8'hF1), 4'd2, 1'b1, 0);
    run_queue();

    // Starvation gap between two vectors.
    enqueue(rand_vec(), 4'd5, 1'b0, 0);
    enqueue(rand_vec(), 4'd3, 1'b1, 3);
    run_queue();

    // Backpressure: valid held high.
    for (int i = 0; i < 6; i++) enqueue(rand_vec(), 4'($urandom_range(1, 8)), 1'($urandom), 0);
    run_queue();

    // Precision clamp.
    enqueue(rand_vec(), 4'd0, 1'b0, 0);
    run_queue();
    enqueue(rand_vec(), 4'd12, 1'b1, 0);
    run_queue();

    // Random traffic including precision 1 and out-of-range precisions.
    for (int i = 0; i < 60; i++)
      enqueue(rand_vec(), 4'($urandom_range(0, 15)), 1'($urandom), (($urandom % 3) == 0) ? int'($urandom_range(0, 3)) : 0);
    run_queue();

    // Reset at bit 3 of a prec-8 vector.
    enqueue(rand_vec(), 4'd8, 1'b1, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin tick(1'b0); guard++; end
    check_val("reset_vec_accept", q.size(), 0);
    guard = 0;
    while (cyc < last_start + 3 && guard < 20) begin tick(1'b0); guard++; end
    check_val("reset_align", cyc, last_start + 3);
    tick(1'b1);
    repeat (3) tick(1'b0);
    enqueue(rand_vec(), 4'd6, 1'b1, 0);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stripes_bit_serial_ctrl.md
# stripes_bit_serial_ctrl

Sequencer for one 16-lane Stripes bit-serial MAC unit. It accepts weight vectors over a valid/ready handshake, double-buffers them, and streams their bits MSB-first at a per-vector precision. It drives the MAC's `en`, `is_msb`, `delayed_is_msb` and `w_bit` inputs, and flags the single cycle in which the MAC's `result` holds a finished dot product. It sits between the weight buffer and `mac_unit_Stripes_16`; activations are held stable by upstream for each vector's streaming window.

## Interface
- `DATA_WIDTH`, 8: stored weight width.
- `VEC_LENGTH`, 16: number of lanes.
- `MAX_PREC`, 8: maximum serialized precision, ≤ DATA_WIDTH.
- `PREC_W`, $clog2(MAX_PREC+1): width of the precision field.
- Clocking: reset reset, synchronous, active-high; clock clk.
- `clk`  in  1  clock.
- `reset`  in  1  clears all state.
- `w_valid`  in  1  weight vector offered.
- `w_ready`  out  1  shadow buffer empty.
- `w_data`  in  [DATA_WIDTH-1:0] x VEC_LENGTH  weight vector, two's complement at `w_prec`.
- `w_prec`  in  PREC_W  bits to stream for this vector; sampled with `w_data`.
- `w_last`  in  1  this vector ends an output group; returned on `res_last`.
- `act_adv`  out  1  pulse: upstream must present the next activation vector from the next cycle on.
- `mac_en`  out  1  → MAC `en`.
- `is_msb`  out  1  → MAC `is_msb`.
- `delayed_is_msb`  out  1  → MAC `delayed_is_msb`.
- `w_bit`  out  1 x VEC_LENGTH  → MAC `w_bit`.
- `res_valid`  out  1  MAC `result` is final this cycle.
- `res_last`  out  1  qualifies `res_valid`.
- `busy`  out  1  not IDLE, or the shadow buffer is full.

## Operation
- **Buffers.**
  - Active register plus one shadow register, each holding data, prec and last.
  - A handshake (`w_valid && w_ready`) writes the shadow.
  - `w_ready` = shadow empty.
- **Precision.** `w_prec` values 0 and >MAX_PREC are treated as MAX_PREC.
- **FSM states:** IDLE, STREAM, DRAIN. Bit counter `bidx` counts down from prec-1 to 0.
- **IDLE**
  - With the shadow full: move shadow to active, set `bidx` = prec-1, go to STREAM.
  - The move happens in the same cycle the first bit issues, so no bubble is inserted.
- **STREAM**
  - Outputs: `mac_en`=1, `w_bit[j]` = active.data[j][bidx], `is_msb` = (bidx == prec-1).
  - While bidx ≠ 0: decrement `bidx`.
  - When bidx = 0 and the shadow is full: reload the active register from the shadow and stay in STREAM. The next vector's MSB issues in the following cycle.
  - When bidx = 0 and the shadow is empty: go to DRAIN.
- **DRAIN**
  - One cycle with `mac_en`=1, `w_bit` all 0, `is_msb`=0. This pushes the last partial sum into the accumulator.
  - Then go to IDLE.
  - A handshake during DRAIN is accepted; that vector starts from IDLE in the next cycle.
- **Activation advance.** `act_adv` pulses in every cycle where `bidx` = 0 in STREAM.
- **`delayed_is_msb`** is a register: loads `is_msb` when `mac_en`=1, holds otherwise, resets to 0.
- **Completion tracking.**
  - Each vector's final-bit cycle L launches a 2-stage valid/last pipeline, advanced on `mac_en`.
  - `res_valid` asserts for exactly one cycle, L+2, with `res_last` = that vector's last flag.
  - Cycle L+1 is always a `mac_en` cycle (the next vector's MSB or DRAIN), so the result is never lost.
- **Reset values:** all outputs 0, except `w_ready`=1; state IDLE; shadow empty; pipelines cleared.
- **Reset mid-stream** abandons the vector. No `res_valid` is produced for it.

## Timing
- Vector with prec p whose first bit issues in cycle t:
  - `is_msb` high in cycle t.
  - `delayed_is_msb` high in cycle t+1.
  - Last bit in cycle t+p-1.
  - `res_valid` in cycle t+p+1.
- Back-to-back vectors: next `is_msb` in cycle t+p; throughput is p cycles per vector.
- Isolated vector: p+1 `mac_en` cycles (including DRAIN), then IDLE.
- Latency from handshake to first bit:
  - 1 cycle when IDLE.
  - Otherwise, the cycle after the current vector's last bit.
- prec = 1: `is_msb` and the last bit fall in the same cycle; `act_adv` pulses every cycle.
- A simultaneous handshake and shadow→active move in the same cycle is legal. The shadow is read before it is written; `w_ready` is registered and reflects occupancy at the start of the cycle.

## Structure
- Package `stripes_ctrl_pkg` holds:
  - the state enum `ctrl_state_e` (IDLE/STREAM/DRAIN);
  - localparams `MAX_PREC` and `PREC_W`;
  - the function `clamp_prec`.
- Sub-module `weight_bit_serializer` holds the active register, the `bidx` counter and the lane bit mux. It outputs `w_bit`, `is_msb` and `last_bit`.
- The FSM, shadow buffer and result pipeline stay in the top module.

## Test plan
- **Single vector.** Prec 8, all lanes 8'h81, isolated.
  - Bits 1,0,0,0,0,0,0,1 on every lane.
  - `is_msb` in cycle 0 only; DRAIN in cycle 8; `res_valid` in cycle 9.
  - The attached MAC reads -127 × Σact.
- **Back-to-back, mixed precision.** Prec 4 vector 4'hF, then prec 2 vector 2'b01, `w_last`=1 on the second.
  - No gap in `mac_en`.
  - `is_msb` in cycles 0 and 4.
  - `res_valid` in cycles 5 and 7; `res_last` = 0 then 1.
- **Starvation.** `w_valid` low for 3 cycles between two vectors.
  - DRAIN occurs, then IDLE holds `mac_en`=0 and `delayed_is_msb` holds.
  - Both results are correct.
- **Backpressure.** `w_valid` held high continuously.
  - `w_ready` deasserts while the shadow is full.
  - Every accepted vector streams exactly once.
- **Reset mid-stream.** Reset at bit 3 of a prec-8 vector.
  - Next cycle: all outputs 0, `w_ready`=1, no `res_valid`.
  - A following vector works normally.
- **Precision clamp.** `w_prec` = 0 and `w_prec` = 12.
  - Each streams 8 bits; `res_valid` in cycle 9.
